// File: rtl/mem_access_stage_pkg.sv
// Shared constants and types for the RV32I memory-access stage:
// load/store funct3 codes, FSM states, the captured-op record.
package mem_access_stage_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_WAIT = 2'd2
  } ma_state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] lane;
    logic       is_load;
    logic [4:0] rd;
    logic       reg_write;
  } ma_op_t;

  // Access size lives in funct3[1:0]; unknown size 2'b11 is checked like a word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-cache request/response channel between the memory stage (master)
// and the data cache (slave).
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic                 cache_req_valid;
  logic                 cache_req_ready;
  logic                 cache_req_we;
  logic [XLEN-1:0]      cache_req_addr;
  logic [XLEN-1:0]      cache_req_wdata;
  logic [NUM_LANES-1:0] cache_req_be;
  logic                 cache_resp_valid;
  logic [XLEN-1:0]      cache_resp_rdata;

  modport master (
    output cache_req_valid, cache_req_we, cache_req_addr, cache_req_wdata, cache_req_be,
    input  cache_req_ready, cache_resp_valid, cache_resp_rdata
  );

  modport slave (
    input  cache_req_valid, cache_req_we, cache_req_addr, cache_req_wdata, cache_req_be,
    output cache_req_ready, cache_resp_valid, cache_resp_rdata
  );

endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Picks the addressed byte/halfword out of a cache read word and
// sign- or zero-extends it according to the load funct3.
module mem_access_stage_load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(rdata >> {addr, 3'b000});
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I memory-access stage: one outstanding data-cache access at a time,
// store lane shaping, load alignment, registered single-cycle writeback.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [N-1:0]            in_alu_out,
  input  logic [N-1:0]            in_store_data,
  input  logic [2:0]              in_funct3,
  input  logic                    in_mem_read,
  input  logic                    in_mem_write,
  input  logic [4:0]              in_rd,
  input  logic                    in_reg_write,
  output logic                    stall,
  mem_access_stage_if.master      cache,
  output logic                    wb_valid,
  output logic [N-1:0]            wb_data,
  output logic [4:0]              wb_rd,
  output logic                    wb_reg_write,
  output logic                    misaligned
);

  ma_state_e            state_q, state_d;
  ma_op_t               op_q, op_d;
  logic                 req_valid_q, req_valid_d;
  logic                 req_we_q, req_we_d;
  logic [N-1:0]         req_addr_q, req_addr_d;
  logic [N-1:0]         req_wdata_q, req_wdata_d;
  logic [NUM_LANES-1:0] req_be_q, req_be_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [N-1:0]         wb_data_q, wb_data_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic                 wb_reg_write_q, wb_reg_write_d;
  logic                 misaligned_q, misaligned_d;

  logic                 is_mem, is_load, mis;
  logic [NUM_LANES-1:0] st_be;
  logic [N-1:0]         st_wdata;
  logic [N-1:0]         load_data;

  // Both read and write set is illegal; it falls through as a load.
  assign is_mem  = in_mem_read | in_mem_write;
  assign is_load = in_mem_read;
  assign mis     = is_misaligned(in_funct3, in_alu_out[1:0]);

  mem_access_stage_load_extend u_load_extend (
    .rdata  (cache.cache_resp_rdata),
    .addr   (op_q.lane),
    .funct3 (op_q.funct3),
    .data   (load_data)
  );

  // Replicate the store operand across lanes; byte enables pick the live ones.
  always_comb begin
    st_be    = '1;
    st_wdata = '0;
    if (!is_load) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        case (in_funct3[1:0])
          F3_SB[1:0]: st_wdata[l*8 +: 8] = in_store_data[7:0];
          F3_SH[1:0]: st_wdata[l*8 +: 8] = in_store_data[(l%2)*8 +: 8];
          default:    st_wdata[l*8 +: 8] = in_store_data[l*8 +: 8];
        endcase
      end
      case (in_funct3[1:0])
        F3_SB[1:0]: st_be = 4'b0001 << in_alu_out[1:0];
        F3_SH[1:0]: st_be = 4'b0011 << in_alu_out[1:0];
        default:    st_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    req_valid_d    = req_valid_q;
    req_we_d       = req_we_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_be_d       = req_be_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    misaligned_d   = 1'b0;
    stall          = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_data_d      = in_alu_out;
            wb_rd_d        = in_rd;
            wb_reg_write_d = in_reg_write;
          end else if (mis) begin
            // No cache traffic; the core traps on the misaligned pulse.
            wb_valid_d     = 1'b1;
            wb_data_d      = '0;
            wb_rd_d        = in_rd;
            wb_reg_write_d = 1'b0;
            misaligned_d   = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = MA_REQ;
            op_d        = '{funct3: in_funct3, lane: in_alu_out[1:0], is_load: is_load,
                            rd: in_rd, reg_write: in_reg_write};
            req_valid_d = 1'b1;
            req_we_d    = !is_load;
            req_addr_d  = {in_alu_out[N-1:2], 2'b00};
            req_wdata_d = st_wdata;
            req_be_d    = st_be;
          end
        end
      end
      MA_REQ: begin
        stall = 1'b1;
        if (cache.cache_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = MA_WAIT;
        end
      end
      MA_WAIT: begin
        stall = 1'b1;
        if (cache.cache_resp_valid) begin
          wb_valid_d     = 1'b1;
          wb_rd_d        = op_q.rd;
          wb_data_d      = op_q.is_load ? load_data : '0;
          wb_reg_write_d = op_q.is_load & op_q.reg_write;
          state_d        = MA_IDLE;
        end
      end
      default: state_d = MA_IDLE;
    endcase
    stall = stall & ~reset;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= MA_IDLE;
      op_q           <= '0;
      req_valid_q    <= 1'b0;
      req_we_q       <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_be_q       <= '0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      misaligned_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      req_valid_q    <= req_valid_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_be_q       <= req_be_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      misaligned_q   <= misaligned_d;
    end
  end

  assign cache.cache_req_valid = req_valid_q;
  assign cache.cache_req_we    = req_we_q;
  assign cache.cache_req_addr  = req_addr_q;
  assign cache.cache_req_wdata = req_wdata_q;
  assign cache.cache_req_be    = req_be_q;
  assign wb_valid              = wb_valid_q;
  assign wb_data               = wb_data_q;
  assign wb_rd                 = wb_rd_q;
  assign wb_reg_write          = wb_reg_write_q;
  assign misaligned            = misaligned_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the ALU in the RV32I core.
- Consumes the ALU result as a data address (loads/stores) or as a plain result (everything else).
- Issues one request at a time to the data cache over a valid/ready request channel and a response channel.
- Aligns and extends load data, and delivers a registered writeback record; stalls upstream while a cache access is outstanding.

Parameters:
- N, 32, datapath and address width; only 32 is supported.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX result is valid this cycle.
- in_alu_out  in  N  ALU result: address for memory ops, result otherwise.
- in_store_data  in  N  rs2 value for stores.
- in_funct3  in  3  load/store width/sign selector (LB/LH/LW/LBU/LHU/SB/SH/SW).
- in_mem_read  in  1  instruction is a load.
- in_mem_write  in  1  instruction is a store.
- in_rd  in  5  destination register.
- in_reg_write  in  1  instruction writes rd.
- stall  out  1  upstream must hold its in_* values.
- cache_req_valid  out  1  cache request valid.
- cache_req_ready  in  1  cache accepts the request.
- cache_req_we  out  1  1 = store.
- cache_req_addr  out  N  word-aligned address, {addr[31:2], 2'b00}.
- cache_req_wdata  out  N  store data shifted into the addressed lanes.
- cache_req_be  out  4  byte enables.
- cache_resp_valid  in  1  response or store acknowledge.
- cache_resp_rdata  in  N  read word.
- wb_valid  out  1  writeback record valid for one cycle.
- wb_data  out  N  result to write back.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  register-file write enable.
- misaligned  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. A reset in any state abandons any outstanding request; a cache_resp_valid arriving after reset is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, in_valid=1, not a memory op: the record is registered, and wb_valid=1 the next cycle with wb_data=in_alu_out (latency 1). stall=0.
- IDLE, memory op, aligned: capture the op, rd and reg_write. Next cycle enter REQ with cache_req_* registered.
  - stall=1 combinationally in this cycle, and stays 1 until the cycle wb_valid is asserted.
- Misaligned rule: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No cache request is issued.
  - Next cycle: wb_valid=1, wb_reg_write=0, misaligned=1.
  - stall=0 (the core takes the trap from misaligned).
- REQ: hold cache_req_* constant until cache_req_ready=1. On the ready cycle, drop cache_req_valid next cycle and enter WAIT. Ready and response in the same cycle are not allowed by the cache protocol.
- WAIT: on cache_resp_valid, register the writeback and return to IDLE, with wb_valid=1 the following cycle.
  - Loads: wb_reg_write=in_reg_write.
  - Stores: wb_reg_write=0, wb_data=0.
- Load extraction (lane = addr[1:0]):
  - LB/LBU: byte lane, sign- or zero-extended to 32 bits.
  - LH/LHU: halfword at addr[1]*16, sign- or zero-extended.
  - LW: whole word.
- Store shaping:
  - SB: be = 4'b0001<<lane; wdata = byte replicated to all four lanes.
  - SH: be = 4'b0011<<lane; wdata = halfword replicated.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, we=0.
- in_mem_read and in_mem_write both set is illegal; in that case the block treats the op as a load.
- wb_valid is a single-cycle pulse per accepted instruction. A new op may be accepted in IDLE in the same cycle wb_valid is high.
- Best-case load latency: accept at T, request at T+1 with ready=1, response at T+2, wb_valid at T+3.

Decomposition:
- Shared constants header (existing constants.v): funct3 codes (`LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW) and FSM state encodings (`MA_IDLE, `MA_REQ, `MA_WAIT).
- One combinational sub-module, load_extend: inputs rdata, addr[1:0], funct3; output the aligned, extended 32-bit value.
- Store shaping and the FSM stay in the top module.

Test Plan:
- ADD result 0x0000_0042, rd=5, no mem op → wb_valid next cycle, wb_data=0x42, wb_rd=5, stall never asserted, cache_req_valid stays 0.
- LB at 0x0000_0103, resp word 0x80FF_1234 → wb_data=0xFFFF_FF80; repeat with LBU → 0x0000_0080; cache_req_addr=0x0000_0100, be=4'b1111.
- SH at 0x0000_0102, rs2=0x1234_ABCD → cache_req_we=1, be=4'b1100, wdata=0xABCD_ABCD; after ack, wb_valid=1 with wb_reg_write=0.
- LW at 0x0000_0102 → misaligned=1 and wb_valid=1 next cycle, wb_reg_write=0, no cache_req_valid ever.
- LW with cache_req_ready low for 3 cycles → cache_req_addr/we/be stable each cycle, stall=1 throughout; resp 0xDEAD_BEEF → wb_data=0xDEAD_BEEF.
- Reset asserted in WAIT → next cycle all outputs 0, state IDLE; a later cache_resp_valid produces no wb_valid.
